// File: rtl/mem_lsu_master_if.sv
// Request/response and memory-port bundle of the load/store initiator.
// The master modport is the LSU view; the slave modport is the execute stage plus memory.
interface mem_lsu_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rw;
  logic [31:0] mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_rw
  );
endinterface

// File: rtl/mem_lsu_master.sv
// Single-outstanding load/store initiator for a word-wide memory port without byte
// enables; sub-word stores are done as read-modify-write.
module mem_lsu_master #(
  parameter int unsigned READ_LATENCY = 32'd1
) (
  input logic              clk,
  input logic              nreset,
  mem_lsu_master_if.master bus_io
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;
  localparam logic [3:0] LAT_LAST = 4'(READ_LATENCY - 32'd1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] sdata_q, sdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_rw_q, mem_rw_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      2'b10:   r = (off != 2'b00);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = sgn ? {{24{b[7]}}, b} : {24'h00_0000, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] data,
                                              input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    case (size)
      2'b00:   r = (old & ~(32'h0000_00FF << {off, 3'b000})) |
                   ({24'h00_0000, data[7:0]} << {off, 3'b000});
      2'b01:   r = off[1] ? {data, old[15:0]} : {old[31:16], data};
      default: r = old;
    endcase
    return r;
  endfunction

  // Next-state and registered-output logic; rsp_valid and mem_rw are one-cycle pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    sdata_d     = sdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rw_d    = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.req_valid) begin
          we_d       = bus_io.req_we;
          size_d     = bus_io.req_size;
          signed_d   = bus_io.req_signed;
          off_d      = bus_io.req_addr[1:0];
          sdata_d    = bus_io.req_wdata[15:0];
          mem_addr_d = {bus_io.req_addr[31:2], 2'b00};
          cnt_d      = 4'd0;
          if (is_illegal(bus_io.req_size, bus_io.req_addr[1:0])) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'h0000_0000;
          end else if (bus_io.req_we && (bus_io.req_size == 2'b10)) begin
            state_d     = ST_WR;
            mem_wdata_d = bus_io.req_wdata;
            mem_rw_d    = 1'b1;
          end else begin
            state_d = ST_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == LAT_LAST) begin
          // Loads finish here; sub-word stores turn the captured word into the merged write
          if (we_q) begin
            state_d     = ST_WR;
            mem_wdata_d = store_merge(bus_io.mem_rdata, sdata_q, size_q, off_q);
            mem_rw_d    = 1'b1;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = load_extract(bus_io.mem_rdata, size_q, off_q, signed_q);
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      sdata_q     <= 16'h0000;
      mem_addr_q  <= 32'h0000_0000;
      mem_wdata_q <= 32'h0000_0000;
      mem_rw_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      sdata_q     <= sdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rw_q    <= mem_rw_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus_io.req_ready = (state_q == ST_IDLE);
  assign bus_io.rsp_valid = rsp_valid_q;
  assign bus_io.rsp_rdata = rsp_rdata_q;
  assign bus_io.rsp_err   = rsp_err_q;
  assign bus_io.mem_addr  = mem_addr_q;
  assign bus_io.mem_wdata = mem_wdata_q;
  assign bus_io.mem_rw    = mem_rw_q;

endmodule

// File: tb/tb_mem_lsu_master.sv
// Directed bench for mem_lsu_master: two instances (READ_LATENCY 1 and 3) share a
// behavioural word memory; sel picks which instance the request tasks drive and observe.
module tb_mem_lsu_master;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic sel = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic [31:0] mem [0:1023];
  int wr_cnt = 0;
  logic [31:0] last_waddr = 32'h0, last_wdata = 32'h0;
  int n_checks = 0, n_fail = 0;

  mem_lsu_master_if ifa ();
  mem_lsu_master_if ifb ();

  mem_lsu_master #(.READ_LATENCY(32'd1)) dut_a (.clk(clk), .nreset(nreset), .bus_io(ifa.master));
  mem_lsu_master #(.READ_LATENCY(32'd3)) dut_b (.clk(clk), .nreset(nreset), .bus_io(ifb.master));

  always #5 clk = ~clk;

  assign ifa.req_valid = req_valid & ~sel;
  assign ifb.req_valid = req_valid & sel;
  assign ifa.req_we = req_we;         assign ifb.req_we = req_we;
  assign ifa.req_size = req_size;     assign ifb.req_size = req_size;
  assign ifa.req_signed = req_signed; assign ifb.req_signed = req_signed;
  assign ifa.req_addr = req_addr;     assign ifb.req_addr = req_addr;
  assign ifa.req_wdata = req_wdata;   assign ifb.req_wdata = req_wdata;
  assign ifa.mem_rdata = mem[ifa.mem_addr[11:2]];
  assign ifb.mem_rdata = mem[ifb.mem_addr[11:2]];

  logic req_ready_m, rsp_valid_m, rsp_err_m, mem_rw_m;
  logic [31:0] rsp_rdata_m, mem_addr_m, mem_wdata_m;
  assign req_ready_m = sel ? ifb.req_ready : ifa.req_ready;
  assign rsp_valid_m = sel ? ifb.rsp_valid : ifa.rsp_valid;
  assign rsp_err_m   = sel ? ifb.rsp_err   : ifa.rsp_err;
  assign rsp_rdata_m = sel ? ifb.rsp_rdata : ifa.rsp_rdata;
  assign mem_rw_m    = sel ? ifb.mem_rw    : ifa.mem_rw;
  assign mem_addr_m  = sel ? ifb.mem_addr  : ifa.mem_addr;
  assign mem_wdata_m = sel ? ifb.mem_wdata : ifa.mem_wdata;

  // Behavioural memory: a write commits on the rising edge that ends a mem_rw cycle
  always @(posedge clk) begin
    if (ifa.mem_rw) begin
      mem[ifa.mem_addr[11:2]] = ifa.mem_wdata;
      last_waddr = ifa.mem_addr; last_wdata = ifa.mem_wdata; wr_cnt = wr_cnt + 1;
    end
    if (ifb.mem_rw) begin
      mem[ifb.mem_addr[11:2]] = ifb.mem_wdata;
      last_waddr = ifb.mem_addr; last_wdata = ifb.mem_wdata; wr_cnt = wr_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One complete request; lat = edge count from accept to the edge that sees rsp_valid high
  task automatic do_req(input logic s, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nwr, output logic after_v, output logic after_rdy);
    int k, w0;
    sel = s; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    k = 0;
    while (!req_ready_m && k < 200) begin step(); k++; end
    w0 = wr_cnt;
    step();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid_m && k < 200) begin step(); k++; end
    lat = k + 1; rdata = rsp_rdata_m; err = rsp_err_m;
    step();
    after_v = rsp_valid_m; after_rdy = req_ready_m; nwr = wr_cnt - w0;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    step(); step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      n_checks++; if (req_ready_m !== 1'b1) begin n_fail++; $display("FAIL reset_ready sel=%0d got %b exp 1", s, req_ready_m); end
      n_checks++; if ({rsp_valid_m, rsp_err_m, mem_rw_m} !== 3'b000) begin n_fail++; $display("FAIL reset_flags sel=%0d got %b exp 000", s, {rsp_valid_m, rsp_err_m, mem_rw_m}); end
      n_checks++; if ({rsp_rdata_m, mem_addr_m, mem_wdata_m} !== 96'h0) begin n_fail++; $display("FAIL reset_words sel=%0d got %h exp 0", s, {rsp_rdata_m, mem_addr_m, mem_wdata_m}); end
    end
    nreset = 1'b1;
    step();
  endtask

  task automatic test_word_roundtrip();
    logic [31:0] rd; logic err, av, ar; int lat, nwr;
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, rd, err, lat, nwr, av, ar);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wstore_lat got %0d exp 2", lat); end
    n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL wstore_writes got %0d exp 1", nwr); end
    n_checks++; if ({last_waddr, last_wdata} !== {32'h100, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wstore_bus got %h/%h exp 00000100/deadbeef", last_waddr, last_wdata); end
    n_checks++; if ({err, rd} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL wstore_rsp got err=%b rd=%h exp 0/0", err, rd); end
    n_checks++; if ({av, ar} !== 2'b01) begin n_fail++; $display("FAIL wstore_pulse got v=%b rdy=%b exp 0/1", av, ar); end
    do_req(1'b0, 1'b0, 2'b10, 1'b1, 32'h100, 32'h0, rd, err, lat, nwr, av, ar);
    n_checks++; if ({err, rd} !== {1'b0, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL wload_rsp got err=%b rd=%h exp 0/deadbeef", err, rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wload_lat got %0d exp 2", lat); end
    n_checks++; if (nwr !== 0) begin n_fail++; $display("FAIL wload_writes got %0d exp 0", nwr); end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd; logic err, av, ar; int lat, nwr;
    logic [31:0] addrs [6] = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h202, 32'h200};
    logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic        sgns  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF, 32'h0000_00FF, 32'h80FF_7F01};
    mem[32'h200 >> 2] = 32'h80FF_7F01;
    for (int i = 0; i < 6; i++) begin
      do_req(i[0], 1'b0, sizes[i], sgns[i], addrs[i], 32'h0, rd, err, lat, nwr, av, ar);
      n_checks++; if ({err, rd} !== {1'b0, exps[i]}) begin n_fail++; $display("FAIL subload_%0d got err=%b rd=%h exp 0/%h", i, err, rd, exps[i]); end
      n_checks++; if (lat !== (i[0] ? 4 : 2)) begin n_fail++; $display("FAIL subload_lat_%0d got %0d exp %0d", i, lat, i[0] ? 4 : 2); end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic err, av, ar; int lat, nwr;
    mem[32'h200 >> 2] = 32'h1122_3344;
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h201, 32'h0000_00AA, rd, err, lat, nwr, av, ar);
    n_checks++; if (nwr !== 1) begin n_fail++; $display("FAIL bstore_writes got %0d exp 1", nwr); end
    n_checks++; if ({last_waddr, last_wdata} !== {32'h200, 32'h1122_AA44}) begin n_fail++; $display("FAIL bstore_bus got %h/%h exp 00000200/1122aa44", last_waddr, last_wdata); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bstore_lat got %0d exp 3", lat); end
    n_checks++; if ({err, rd, av, ar} !== {1'b0, 32'h0, 2'b01}) begin n_fail++; $display("FAIL bstore_rsp got err=%b rd=%h v=%b rdy=%b", err, rd, av, ar); end
    do_req(1'b1, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_BEEF, rd, err, lat, nwr, av, ar);
    n_checks++; if ({nwr, mem[32'h200 >> 2]} !== {32'd1, 32'hBEEF_AA44}) begin n_fail++; $display("FAIL hstore_word got n=%0d w=%h exp 1/beefaa44", nwr, mem[32'h200 >> 2]); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL hstore_lat got %0d exp 5", lat); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic err, av, ar; int lat, nwr;
    logic [31:0] addrs [4] = '{32'h102, 32'h101, 32'h100, 32'h106};
    logic [1:0]  sizes [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic        wes   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      do_req(i[0], wes[i], sizes[i], 1'b0, addrs[i], 32'h5555_5555, rd, err, lat, nwr, av, ar);
      n_checks++; if ({err, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL misalign_rsp_%0d got err=%b rd=%h exp 1/0", i, err, rd); end
      n_checks++; if ({lat, nwr} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL misalign_timing_%0d got lat=%0d writes=%0d exp 1/0", i, lat, nwr); end
    end
  endtask

  task automatic test_back_to_back(input logic s);
    int k, busy_bad;
    logic [31:0] addrs [3] = '{32'h100, 32'h300, 32'h302};
    logic [1:0]  sizes [3] = '{2'b10, 2'b10, 2'b01};
    logic [31:0] exps  [3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_CAFE};
    mem[32'h300 >> 2] = 32'hCAFE_F00D;
    sel = s; req_we = 1'b0; req_signed = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr = addrs[i]; req_size = sizes[i];
      k = 0;
      while (!req_ready_m && k < 200) begin step(); k++; end
      step();
      k = 0; busy_bad = 0;
      while (!rsp_valid_m && k < 200) begin if (req_ready_m) busy_bad++; step(); k++; end
      if (req_ready_m) busy_bad++;
      n_checks++; if (rsp_rdata_m !== exps[i]) begin n_fail++; $display("FAIL b2b_data s=%0d i=%0d got %h exp %h", s, i, rsp_rdata_m, exps[i]); end
      n_checks++; if (k + 1 !== (s ? 4 : 2)) begin n_fail++; $display("FAIL b2b_lat s=%0d i=%0d got %0d exp %0d", s, i, k + 1, s ? 4 : 2); end
      n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL b2b_ready_busy s=%0d i=%0d got %0d ready cycles exp 0", s, i, busy_bad); end
    end
    req_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_abort();
    int w0, seen;
    mem[32'h204 >> 2] = 32'h0BAD_F00D;
    mem[32'h104 >> 2] = 32'h1357_9BDF;
    w0 = wr_cnt;
    // Byte store on the slow instance, reset while still reading
    sel = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h205; req_wdata = 32'h77; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    nreset = 1'b0; #1;
    n_checks++; if ({mem_rw_m, rsp_valid_m, req_ready_m} !== 3'b001) begin n_fail++; $display("FAIL abort_rd got rw=%b v=%b rdy=%b exp 0/0/1", mem_rw_m, rsp_valid_m, req_ready_m); end
    step(); nreset = 1'b1;
    // Word store on the fast instance, reset during the write cycle
    sel = 1'b0; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h104; req_wdata = 32'hFFFF_0000; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    n_checks++; if (mem_rw_m !== 1'b1) begin n_fail++; $display("FAIL abort_wr_pre got rw=%b exp 1", mem_rw_m); end
    nreset = 1'b0; #1;
    n_checks++; if (mem_rw_m !== 1'b0) begin n_fail++; $display("FAIL abort_wr got rw=%b exp 0", mem_rw_m); end
    step(); nreset = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ifa.rsp_valid || ifb.rsp_valid || !ifa.req_ready || !ifb.req_ready) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_quiet got %0d bad cycles exp 0", seen); end
    n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL abort_writes got %0d exp 0", wr_cnt - w0); end
    n_checks++; if ({mem[32'h204 >> 2], mem[32'h104 >> 2]} !== {32'h0BAD_F00D, 32'h1357_9BDF}) begin n_fail++; $display("FAIL abort_mem got %h/%h", mem[32'h204 >> 2], mem[32'h104 >> 2]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    #1;
    test_reset();
    test_word_roundtrip();
    test_subword_loads();
    test_rmw();
    test_misaligned();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
